decode_queue: RTL

Parametrised instruction buffer plus decoder between fetch and the reservation-station dispatch logic of the out-of-order RV32 core. It accepts one raw instruction and PC per cycle from fetch over a valid/ready handshake and holds up to DEPTH entries in a FIFO. It presents the head entry decoded into issue fields (Unit, Op, Qj, Qk, Vj, Vk, A, A_rdy, Dest, rwmm) on a second valid/ready handshake. It adds illegal-instruction flagging, optional M-extension routing and a pipeline flush.

---
 rtl/decode_queue.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
// Instruction FIFO between fetch and dispatch. Stores raw {instr, pc} and
// decodes the head entry combinationally into reservation-station issue fields.
module decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter bit          RV32M = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_Unit,
    output logic [9:0]               out_Op,
    output logic [4:0]               out_Qj,
    output logic [4:0]               out_Qk,
    output logic [31:0]              out_Vj,
    output logic [31:0]              out_Vk,
    output logic [31:0]              out_A,
    output logic                     out_A_rdy,
    output logic [4:0]               out_Dest,
    output logic [2:0]               out_rwmm,
    output logic                     out_illegal,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [2:0] {
        U_ALU    = 3'd0,
        U_MUL    = 3'd1,
        U_DIV    = 3'd2,
        U_BRANCH = 3'd3,
        U_LOAD   = 3'd4,
        U_STORE  = 3'd5
    } unit_e;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'h03,
        OPC_MISC_MEM = 7'h0F,
        OPC_OP_IMM   = 7'h13,
        OPC_AUIPC    = 7'h17,
        OPC_STORE    = 7'h23,
        OPC_OP       = 7'h33,
        OPC_LUI      = 7'h37,
        OPC_BRANCH   = 7'h63,
        OPC_JALR     = 7'h67,
        OPC_JAL      = 7'h6F,
        OPC_SYSTEM   = 7'h73
    } opcode_e;

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // flush wins over any handshake in the same cycle
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_instr, in_pc};
    end

    logic [31:0] h_instr, h_pc;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign {h_instr, h_pc} = mem_q[rd_ptr_q];
    assign opc = h_instr[6:0];
    assign rd  = h_instr[11:7];
    assign f3  = h_instr[14:12];
    assign rs1 = h_instr[19:15];
    assign rs2 = h_instr[24:20];
    assign f7  = h_instr[31:25];

    assign imm_i = {{20{h_instr[31]}}, h_instr[31:20]};
    assign imm_s = {{20{h_instr[31]}}, h_instr[31:25], h_instr[11:7]};
    assign imm_b = {{19{h_instr[31]}}, h_instr[31], h_instr[7], h_instr[30:25],
                    h_instr[11:8], 1'b0};
    assign imm_u = {h_instr[31:12], 12'b0};
    assign imm_j = {{11{h_instr[31]}}, h_instr[31], h_instr[19:12], h_instr[20],
                    h_instr[30:21], 1'b0};

    always_comb begin
        out_Unit    = U_ALU;
        out_Op      = '0;
        out_Qj      = '0;
        out_Qk      = '0;
        out_Vj      = '0;
        out_Vk      = '0;
        out_A       = '0;
        out_A_rdy   = 1'b0;
        out_Dest    = '0;
        out_rwmm    = '0;
        out_illegal = 1'b0;
        out_pc      = '0;
        if (out_valid) begin
            out_pc    = h_pc;
            out_A_rdy = 1'b1;
            out_Dest  = rd;
            case (opc)
                OPC_OP_IMM: begin
                    out_Op = {f3, (f3 == 3'b101) ? f7 : 7'b0};
                    out_Qj = rs1;
                    out_Vk = imm_i;
                end
                OPC_LUI: out_Vk = imm_u;
                OPC_AUIPC: begin
                    out_Vj = h_pc;
                    out_Vk = imm_u;
                end
                OPC_OP: begin
                    out_Op = {f3, f7};
                    out_Qj = rs1;
                    out_Qk = rs2;
                    if (f7 == 7'b0000001 && RV32M)
                        out_Unit = f3[2] ? U_DIV : U_MUL;
                    else if (f7 != 7'b0000000 && f7 != 7'b0100000)
                        out_illegal = 1'b1;
                end
                OPC_JAL: begin
                    out_Unit = U_BRANCH;
                    out_A    = h_pc + imm_j;
                end
                OPC_JALR: begin
                    out_Unit  = U_BRANCH;
                    out_Op    = {f3, 7'b0};
                    out_Qj    = rs1;
                    out_Qk    = rs1;
                    out_A     = imm_i;
                    out_A_rdy = 1'b0;
                end
                OPC_BRANCH: begin
                    out_Unit = U_BRANCH;
                    out_Op   = {f3, 7'b0};
                    out_Qj   = rs1;
                    out_Qk   = rs2;
                    out_A    = h_pc + imm_b;
                    out_Dest = '0;
                end
                OPC_LOAD: begin
                    out_Unit  = U_LOAD;
                    out_Qj    = rs1;
                    out_A     = imm_i;
                    out_A_rdy = 1'b0;
                    out_rwmm  = f3;
                end
                OPC_STORE: begin
                    out_Unit  = U_STORE;
                    out_Qj    = rs1;
                    out_Qk    = rs2;
                    out_A     = imm_s;
                    out_A_rdy = 1'b0;
                    out_Dest  = '0;
                    out_rwmm  = f3;
                end
                OPC_MISC_MEM: begin
                    out_Qj   = rs1;
                    out_Dest = '0;
                end
                OPC_SYSTEM: out_Dest = '0;
                default: begin
                    out_Dest    = '0;
                    out_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule
